// File: rtl/top1_pkg.sv
// top1_pkg: shared defaults and limits for the top1_and3 three-input AND block
package top1_pkg;
  localparam int SYNC_STAGES_DEF = 0;
  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_MAX = 3;
endpackage

// File: rtl/top1_and3_and2_cell.sv
// and2_cell: two-input AND leaf cell, cascaded twice inside top1_and3
module and2_cell (
  input  logic a,
  input  logic b,
  output logic s
);
  assign s = a & b;
endmodule

// File: rtl/top1_and3.sv
// top1_and3: 3-input AND with combinational d, optionally synchronized registered d_reg and rise pulse.
// Optional rising-edge counter rise_cnt enabled by defining TOP1_RISE_CNT_EN.
module top1_and3
  import top1_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             d,
`ifdef TOP1_RISE_CNT_EN
  output logic [CNT_W-1:0] rise_cnt,
`endif
  output logic             d_reg,
  output logic             d_rise
);
  logic       s;
  logic [2:0] abc_s;
  logic       d_reg_prev;
  if (SYNC_STAGES > SYNC_STAGES_MAX || SYNC_STAGES < 0 || CNT_W < 1) begin : g_bad_cfg
    $error("top1_and3: SYNC_STAGES must be 0..3 and CNT_W >= 1");
  end
  and2_cell u_and_ab (.a(a), .b(b), .s(s));
  and2_cell u_and_sc (.a(s), .b(c), .s(d));
  if (SYNC_STAGES == 0) begin : g_nosync
    assign abc_s = {a, b, c};
  end else begin : g_sync
    logic [2:0] q [SYNC_STAGES];
    always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n)
        for (int i = 0; i < SYNC_STAGES; i++) q[i] <= '0;
      else begin
        q[0] <= {a, b, c};
        for (int i = 1; i < SYNC_STAGES; i++) q[i] <= q[i-1];
      end
    assign abc_s = q[SYNC_STAGES-1];
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      d_reg      <= 1'b0;
      d_reg_prev <= 1'b0;
    end else begin
      d_reg      <= &abc_s;
      d_reg_prev <= d_reg;
    end
  assign d_rise = d_reg & ~d_reg_prev;
`ifdef TOP1_RISE_CNT_EN
  // free-running wrap, no saturation
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) rise_cnt <= '0;
    else            rise_cnt <= rise_cnt + CNT_W'(d_rise);
`endif
endmodule

// File: tb/tb_top1_and3.sv
// tb_top1_and3: directed self-checking bench for top1_and3 (SYNC_STAGES 0 and 2 side by side).
// Counter-wrap checks run only when TOP1_RISE_CNT_EN is defined.
module tb_top1_and3;
  logic sys_clk = 1'b0;
  logic clk_en = 1'b0;
  logic sys_rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0;
  logic d0, d_reg0, d_rise0, d2, d_reg2, d_rise2;
`ifdef TOP1_RISE_CNT_EN
  logic [1:0] cnt0, cnt2;
`endif
  int n_chk = 0;
  int n_fail = 0;
  top1_and3 #(.SYNC_STAGES(0), .CNT_W(2)) u0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .a(a), .b(b), .c(c), .d(d0),
`ifdef TOP1_RISE_CNT_EN
    .rise_cnt(cnt0),
`endif
    .d_reg(d_reg0), .d_rise(d_rise0)
  );
  top1_and3 #(.SYNC_STAGES(2), .CNT_W(2)) u2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .a(a), .b(b), .c(c), .d(d2),
`ifdef TOP1_RISE_CNT_EN
    .rise_cnt(cnt2),
`endif
    .d_reg(d_reg2), .d_rise(d_rise2)
  );
  initial forever #5 if (clk_en) sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  initial begin
    #10;
    chk("rst_dreg0", {7'b0, d_reg0}, 8'd0);
    chk("rst_drise0", {7'b0, d_rise0}, 8'd0);
    chk("rst_dreg2", {7'b0, d_reg2}, 8'd0);
`ifdef TOP1_RISE_CNT_EN
    chk("rst_cnt0", {6'b0, cnt0}, 8'd0);
`endif
    for (int i = 0; i < 8; i++) begin
      {a, b, c} = 3'(i);
      #100;
      chk($sformatf("tt_d0_%0d", i), {7'b0, d0}, (i == 7) ? 8'd1 : 8'd0);
      chk($sformatf("tt_d2_%0d", i), {7'b0, d2}, (i == 7) ? 8'd1 : 8'd0);
      chk($sformatf("tt_dreg_%0d", i), {7'b0, d_reg0}, 8'd0);
    end
    {a, b, c} = 3'b110;
    #3 sys_rst_n = 1'b1;
    clk_en = 1'b1;
    repeat (4) tick();
    chk("lat_pre_dreg0", {7'b0, d_reg0}, 8'd0);
    chk("lat_pre_dreg2", {7'b0, d_reg2}, 8'd0);
    {a, b, c} = 3'b111;
    tick();
    chk("lat1_dreg0", {7'b0, d_reg0}, 8'd1);
    chk("lat1_drise0", {7'b0, d_rise0}, 8'd1);
    chk("lat1_dreg2", {7'b0, d_reg2}, 8'd0);
    tick();
    chk("lat2_dreg0", {7'b0, d_reg0}, 8'd1);
    chk("lat2_drise0", {7'b0, d_rise0}, 8'd0);
    chk("lat2_dreg2", {7'b0, d_reg2}, 8'd0);
    tick();
    chk("lat3_dreg2", {7'b0, d_reg2}, 8'd1);
    chk("lat3_drise2", {7'b0, d_rise2}, 8'd1);
    chk("lat3_drise0", {7'b0, d_rise0}, 8'd0);
    tick();
    chk("lat4_drise2", {7'b0, d_rise2}, 8'd0);
    chk("lat4_dreg2", {7'b0, d_reg2}, 8'd1);
`ifdef TOP1_RISE_CNT_EN
    chk("lat_cnt0", {6'b0, cnt0}, 8'd1);
    chk("lat_cnt2", {6'b0, cnt2}, 8'd1);
`endif
    {a, b, c} = 3'b011;
    tick();
    chk("fall1_dreg0", {7'b0, d_reg0}, 8'd0);
    chk("fall1_dreg2", {7'b0, d_reg2}, 8'd1);
    chk("fall1_drise2", {7'b0, d_rise2}, 8'd0);
    tick();
    chk("fall2_dreg2", {7'b0, d_reg2}, 8'd1);
    chk("fall2_drise2", {7'b0, d_rise2}, 8'd0);
    tick();
    chk("fall3_dreg2", {7'b0, d_reg2}, 8'd0);
    chk("fall3_drise2", {7'b0, d_rise2}, 8'd0);
    {a, b, c} = 3'b111;
    repeat (4) tick();
    chk("ar_pre_dreg0", {7'b0, d_reg0}, 8'd1);
    chk("ar_pre_dreg2", {7'b0, d_reg2}, 8'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("ar_dreg0", {7'b0, d_reg0}, 8'd0);
    chk("ar_dreg2", {7'b0, d_reg2}, 8'd0);
    chk("ar_drise0", {7'b0, d_rise0}, 8'd0);
    chk("ar_drise2", {7'b0, d_rise2}, 8'd0);
    chk("ar_d0", {7'b0, d0}, 8'd1);
`ifdef TOP1_RISE_CNT_EN
    chk("ar_cnt0", {6'b0, cnt0}, 8'd0);
    chk("ar_cnt2", {6'b0, cnt2}, 8'd0);
`endif
    #1 sys_rst_n = 1'b1;
    tick();
    chk("rel1_dreg0", {7'b0, d_reg0}, 8'd1);
    chk("rel1_drise0", {7'b0, d_rise0}, 8'd1);
    chk("rel1_dreg2", {7'b0, d_reg2}, 8'd0);
    tick();
    chk("rel2_drise0", {7'b0, d_rise0}, 8'd0);
    chk("rel2_dreg2", {7'b0, d_reg2}, 8'd0);
    tick();
    chk("rel3_dreg2", {7'b0, d_reg2}, 8'd1);
    chk("rel3_drise2", {7'b0, d_rise2}, 8'd1);
    tick();
    chk("rel4_drise2", {7'b0, d_rise2}, 8'd0);
    c = 1'b0;
    repeat (4) tick();
    #2 c = 1'b1;
    #1;
    chk("gl_d0", {7'b0, d0}, 8'd1);
    #1 c = 1'b0;
    #1;
    chk("gl_d0_back", {7'b0, d0}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("gl_dreg0_%0d", i), {7'b0, d_reg0}, 8'd0);
      chk($sformatf("gl_drise0_%0d", i), {7'b0, d_rise0}, 8'd0);
      chk($sformatf("gl_dreg2_%0d", i), {7'b0, d_reg2}, 8'd0);
    end
`ifdef TOP1_RISE_CNT_EN
    #2 sys_rst_n = 1'b0;
    #1 sys_rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      c = 1'b1;
      tick();
      tick();
      c = 1'b0;
      tick();
      tick();
      chk($sformatf("wrap_cnt0_%0d", k), {6'b0, cnt0}, 8'(k % 4));
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/top1_and3.md
Name: top1_and3

Overview:
- Three-input AND block built as a cascade of two 2-input AND cells: `s = a & b`, `d = s & c`.
- Provides two forms of the result:
  - a purely combinational result `d`, which is the exhaustive-truth-table-compatible path;
  - a registered, optionally synchronized version for use in clocked logic, plus a rising-edge pulse.
- Sits as a small glue/leaf block under a top-level wrapper.

Parameters:
- SYNC_STAGES, 0, number of flip-flop synchronizer stages on each of a/b/c before the registered path. 0 = no synchronizer; legal range 0..3.
- CNT_W, 8, width of the rising-edge counter. Only used when the optional feature is enabled.

Ports:
- sys_clk  input  1  single system clock; all registers are on its rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- a  input  1  AND operand 0.
- b  input  1  AND operand 1.
- c  input  1  AND operand 2.
- d  output  1  combinational `a & b & c`; no clock dependence.
- d_reg  output  1  registered AND of the (synchronized) inputs.
- d_rise  output  1  one-cycle pulse when d_reg goes 0 -> 1.
- rise_cnt  output  CNT_W  count of d_rise pulses; present only with TOP1_RISE_CNT_EN.

Behaviour:
- Combinational path:
  - `d = (a & b) & c` at all times, including during reset.
  - Zero latency.
  - Implemented as two and2_cell instances joined by internal net s.
- Synchronizer:
  - Each input passes through SYNC_STAGES flops.
  - All flops reset to 0.
  - With SYNC_STAGES = 0 the raw inputs feed the register stage directly.
- Registered path:
  - `d_reg <= a_s & b_s & c_s` every rising edge.
  - Total latency from an input change to d_reg is SYNC_STAGES + 1 cycles.
- Edge detect:
  - `d_rise = d_reg & ~d_reg_prev`, where d_reg_prev is d_reg delayed by one cycle.
  - d_rise is registered-based and high for exactly one cycle per 0->1 transition of d_reg.
  - It is not asserted on 1->1 or on 1->0.
- Reset:
  - While sys_rst_n = 0: all flops clear immediately. d_reg = 0, d_reg_prev = 0, d_rise = 0, rise_cnt = 0.
  - Reset asserted mid-operation clears the registered outputs without waiting for a clock edge.
  - On the first edge after release, d_reg samples normally.
  - A d_reg that is 1 on the first post-reset sample produces a d_rise pulse, because prev = 0.
- Input glitches shorter than a clock period affect d only, never d_reg.
- No handshake and no back-pressure.

Optional Feature:
- Macro: TOP1_RISE_CNT_EN.
- Defined:
  - rise_cnt port exists.
  - rise_cnt increments by 1 on every cycle d_rise = 1.
  - Wraps modulo 2^CNT_W: all-ones + 1 = 0, with no saturation or flag.
  - Cleared asynchronously by sys_rst_n.
- Undefined: rise_cnt port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package top1_pkg:
  - localparam defaults SYNC_STAGES_DEF = 0 and CNT_W_DEF = 8;
  - the max-stages constant 3.
- Sub-module and2_cell:
  - ports a, b (inputs) and s (output);
  - function `s = a & b`;
  - instantiated twice in cascade.
- Synchronizer and counter stay inline.

Test Plan:
- Exhaustive truth table: apply abc = 000, 001, 010, 011, 100, 101, 110, 111, holding each 100 ns. Required: d = 0 for the first seven combinations and d = 1 only for 111, with d following inputs with no clock applied.
- Registered latency with SYNC_STAGES = 0 and clock running: step abc 110 -> 111 at an edge. Required: d_reg = 1 one cycle later, d_rise = 1 for exactly one cycle, then 0 while abc stays 111.
- Synchronizer latency with SYNC_STAGES = 2: step abc 011 -> 111. Required: d_reg rises 3 cycles later. Then step abc 111 -> 011. Required: d_reg falls 3 cycles later with no d_rise.
- Async reset mid-run: with d_reg = 1, pull sys_rst_n low between clock edges. Required: d_reg, d_rise and rise_cnt go 0 immediately, while d stays 1. Release reset with abc = 111. Required: d_reg = 1 after SYNC_STAGES + 1 edges, with one d_rise pulse.
- Counter wrap (TOP1_RISE_CNT_EN, CNT_W = 2): toggle c 0/1 every 2 cycles with a = b = 1 to make 5 rising edges. Required: rise_cnt sequence 1, 2, 3, 0, 1.
- Glitch: pulse c high for less than one clock period, entirely between edges, with a = b = 1. Required: d pulses and d_reg/d_rise stay 0.
